// File: rtl/cfs_apb_checker_pkg.sv
// Shared types and constants for the APB protocol checker: FSM states,
// violation codes and the lowest-code priority helper.
package cfs_apb_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    localparam int NUM_ERR          = 6;
    localparam int ERR_PEN_SETUP    = 0;
    localparam int ERR_SETUP_ACCESS = 1;
    localparam int ERR_PEN_DONE     = 2;
    localparam int ERR_UNSTABLE     = 3;
    localparam int ERR_ABORT        = 4;
    localparam int ERR_TIMEOUT      = 5;

    function automatic logic [2:0] lowest_err(input logic [NUM_ERR-1:0] v);
        lowest_err = 3'd0;
        for (int i = NUM_ERR - 1; i >= 0; i--) begin
            if (v[i]) lowest_err = 3'(i);
        end
    endfunction

endpackage

// File: rtl/cfs_apb_sat_cnt.sv
// Saturating event counter; a clear coinciding with an increment yields 1.
module cfs_apb_sat_cnt #(
    parameter int WIDTH = 8
) (
    input  logic             pclk,
    input  logic             preset,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = inc ? WIDTH'(1) : '0;
        end else if (inc && !(&count_q)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) count_q <= '0;
        else        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/cfs_apb_checker.sv
// Passive APB protocol checker with sticky violation flags and counters.
// Optional access-phase timeout (code 5) enabled by CFS_APB_CHECKER_TIMEOUT_EN.
module cfs_apb_checker
    import cfs_apb_checker_pkg::*;
#(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int CNT_WIDTH      = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  chk_en,
    input  logic                  clr,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    input  logic                  pready,
    input  logic                  pslverr,
    output logic [NUM_ERR-1:0]    err_flags,
    output logic                  err_pulse,
    output logic [2:0]            first_err,
    output logic                  first_valid,
    output logic [CNT_WIDTH-1:0]  err_cnt,
    output logic [CNT_WIDTH-1:0]  xfer_cnt,
    output logic [CNT_WIDTH-1:0]  slverr_cnt
);

    apb_state_e            state_q, state_d;
    logic                  done_q, done_d;
    logic [ADDR_WIDTH-1:0] cap_addr_q, cap_addr_d;
    logic [DATA_WIDTH-1:0] cap_data_q, cap_data_d;
    logic                  cap_write_q, cap_write_d;
    logic [NUM_ERR-1:0]    flags_q, flags_d;
    logic [2:0]            first_err_q, first_err_d;
    logic                  first_valid_q, first_valid_d;
    logic                  pulse_q, pulse_d;

    logic                  setup_cycle, access_cycle, complete;
    logic [NUM_ERR-2:0]    err_proto;
    logic                  timeout_det;
    logic [NUM_ERR-1:0]    err_vec;
    logic                  err_any;

    // The state records the phase of the previously sampled bus cycle; done_q
    // marks that the previous cycle completed a transfer.
    always_comb begin
        state_d      = state_q;
        done_d       = 1'b0;
        cap_addr_d   = cap_addr_q;
        cap_data_d   = cap_data_q;
        cap_write_d  = cap_write_q;
        setup_cycle  = 1'b0;
        access_cycle = 1'b0;
        complete     = 1'b0;
        err_proto    = '0;

        case (state_q)
            ST_IDLE: begin
                if (psel) begin
                    setup_cycle = 1'b1;
                    state_d     = ST_SETUP;
                end
            end
            ST_SETUP: begin
                err_proto[ERR_SETUP_ACCESS] = !psel || !penable;
                if (psel) access_cycle = 1'b1;
                state_d = psel ? ST_ACCESS : ST_IDLE;
            end
            ST_ACCESS: begin
                if (done_q) begin
                    err_proto[ERR_PEN_DONE] = penable;
                    setup_cycle = psel;
                    state_d     = psel ? ST_SETUP : ST_IDLE;
                end else if (!psel) begin
                    err_proto[ERR_ABORT] = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    access_cycle = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (setup_cycle) begin
            err_proto[ERR_PEN_SETUP] = penable;
            cap_addr_d  = paddr;
            cap_data_d  = pwdata;
            cap_write_d = pwrite;
        end

        if (access_cycle) begin
            err_proto[ERR_UNSTABLE] = (paddr != cap_addr_q) || (pwrite != cap_write_q) ||
                                      (cap_write_q && (pwdata != cap_data_q));
            complete = penable && pready;
            done_d   = complete;
        end
    end

`ifdef CFS_APB_CHECKER_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WAIT_W-1:0] wait_q, wait_d;

    // Stops counting at the limit so the timeout fires only once per transfer.
    always_comb begin
        wait_d      = wait_q;
        timeout_det = 1'b0;
        if (setup_cycle) begin
            wait_d = '0;
        end else if (access_cycle && !pready && (wait_q != WAIT_W'(TIMEOUT_CYCLES))) begin
            wait_d      = wait_q + WAIT_W'(1);
            timeout_det = (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1));
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) wait_q <= '0;
        else        wait_q <= wait_d;
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
    assign timeout_det    = 1'b0;
`endif

    assign err_vec = chk_en ? {timeout_det, err_proto} : '0;
    assign err_any = |err_vec;

    // A clear at the same edge as a new violation keeps the new violation.
    always_comb begin
        flags_d       = clr ? err_vec : (flags_q | err_vec);
        first_err_d   = first_err_q;
        first_valid_d = first_valid_q;
        pulse_d       = err_any;
        if (clr) begin
            first_valid_d = err_any;
            first_err_d   = err_any ? lowest_err(err_vec) : 3'd0;
        end else if (err_any && !first_valid_q) begin
            first_valid_d = 1'b1;
            first_err_d   = lowest_err(err_vec);
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q       <= ST_IDLE;
            done_q        <= 1'b0;
            cap_addr_q    <= '0;
            cap_data_q    <= '0;
            cap_write_q   <= 1'b0;
            flags_q       <= '0;
            first_err_q   <= 3'd0;
            first_valid_q <= 1'b0;
            pulse_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            done_q        <= done_d;
            cap_addr_q    <= cap_addr_d;
            cap_data_q    <= cap_data_d;
            cap_write_q   <= cap_write_d;
            flags_q       <= flags_d;
            first_err_q   <= first_err_d;
            first_valid_q <= first_valid_d;
            pulse_q       <= pulse_d;
        end
    end

    cfs_apb_sat_cnt #(.WIDTH(CNT_WIDTH)) u_err_cnt (
        .pclk(pclk), .preset(preset), .inc(err_any), .clr(clr), .count(err_cnt)
    );

    cfs_apb_sat_cnt #(.WIDTH(CNT_WIDTH)) u_xfer_cnt (
        .pclk(pclk), .preset(preset), .inc(complete), .clr(clr), .count(xfer_cnt)
    );

    cfs_apb_sat_cnt #(.WIDTH(CNT_WIDTH)) u_slverr_cnt (
        .pclk(pclk), .preset(preset), .inc(complete && pslverr), .clr(clr), .count(slverr_cnt)
    );

    assign err_flags   = flags_q;
    assign err_pulse   = pulse_q;
    assign first_err   = first_err_q;
    assign first_valid = first_valid_q;

endmodule

// File: tb/tb_cfs_apb_checker.sv
// Scoreboard bench for cfs_apb_checker: scenarios queue expected outputs,
// which are then popped and compared against the DUT at the falling edge.
module tb_cfs_apb_checker;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int CW = 8;
    localparam int TO = 16;
`ifdef CFS_APB_CHECKER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          pclk = 1'b0;
    logic          preset, chk_en, clr;
    logic          psel, penable, pwrite, pready, pslverr;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [5:0]    err_flags;
    logic          err_pulse;
    logic [2:0]    first_err;
    logic          first_valid;
    logic [CW-1:0] err_cnt, xfer_cnt, slverr_cnt;

    int checks = 0;
    int failures = 0;
    int pulse_total = 0;
    int pulse_base = 0;

    typedef enum int {O_FLAGS, O_FIRST, O_FVALID, O_ERRCNT, O_XFER, O_SLV, O_PULSES} out_e;
    typedef struct {
        string       tag;
        out_e        sel;
        int unsigned exp;
    } exp_t;
    exp_t sb[$];

    always #5 pclk = ~pclk;

    cfs_apb_checker #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .pclk(pclk), .preset(preset), .chk_en(chk_en), .clr(clr),
        .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pready(pready), .pslverr(pslverr),
        .err_flags(err_flags), .err_pulse(err_pulse), .first_err(first_err),
        .first_valid(first_valid), .err_cnt(err_cnt), .xfer_cnt(xfer_cnt),
        .slverr_cnt(slverr_cnt)
    );

    always @(negedge pclk) if (err_pulse === 1'b1) pulse_total++;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input int unsigned exp);
        checks++;
        if (obs !== 32'(exp)) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] obs_of(input out_e s);
        case (s)
            O_FLAGS:  obs_of = 32'(err_flags);
            O_FIRST:  obs_of = 32'(first_err);
            O_FVALID: obs_of = 32'(first_valid);
            O_ERRCNT: obs_of = 32'(err_cnt);
            O_XFER:   obs_of = 32'(xfer_cnt);
            O_SLV:    obs_of = 32'(slverr_cnt);
            default:  obs_of = 32'(pulse_total - pulse_base);
        endcase
    endfunction

    task automatic push(input string tag, input out_e s, input int unsigned e);
        exp_t x;
        x.tag = tag;
        x.sel = s;
        x.exp = e;
        sb.push_back(x);
    endtask

    task automatic drain();
        exp_t x;
        @(negedge pclk);
        while (sb.size() > 0) begin
            x = sb.pop_front();
            check_eq(x.tag, obs_of(x.sel), x.exp);
        end
    endtask

    // One bus cycle: inputs held across the next rising edge.
    task automatic cyc(input logic s, input logic e, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic r, input logic se);
        psel = s; penable = e; pwrite = w; paddr = a; pwdata = d; pready = r; pslverr = se;
        @(posedge pclk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic xfer(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic w,
                        input int waits, input logic se);
        cyc(1'b1, 1'b0, w, a, d, 1'b0, 1'b0);
        repeat (waits) cyc(1'b1, 1'b1, w, a, d, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, w, a, d, 1'b1, se);
        idle();
    endtask

    task automatic do_clr();
        clr = 1'b1;
        idle();
        clr = 1'b0;
        pulse_base = pulse_total;
    endtask

    initial begin
        preset = 1'b1; chk_en = 1'b1; clr = 1'b0;
        psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0; pready = 0; pslverr = 0;
        #23 preset = 1'b0;
        @(posedge pclk);
        #1;

        push("rst_flags", O_FLAGS, 0);
        push("rst_first", O_FIRST, 0);
        push("rst_fvalid", O_FVALID, 0);
        push("rst_errcnt", O_ERRCNT, 0);
        push("rst_xfer", O_XFER, 0);
        push("rst_slv", O_SLV, 0);
        drain();

        // Legal write with two wait states
        pulse_base = pulse_total;
        xfer(16'h0010, 32'hA5A5A5A5, 1'b1, 2, 1'b0);
        idle();
        push("legal_xfer", O_XFER, 1);
        push("legal_flags", O_FLAGS, 0);
        push("legal_pulses", O_PULSES, 0);
        push("legal_errcnt", O_ERRCNT, 0);
        push("legal_slv", O_SLV, 0);
        drain();

        // penable high during the setup cycle
        do_clr();
        cyc(1'b1, 1'b1, 1'b0, 16'h0020, '0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 16'h0020, '0, 1'b1, 1'b0);
        idle();
        push("pensetup_flags", O_FLAGS, 6'b000001);
        push("pensetup_first", O_FIRST, 0);
        push("pensetup_fvalid", O_FVALID, 1);
        push("pensetup_errcnt", O_ERRCNT, 1);
        push("pensetup_pulses", O_PULSES, 1);
        drain();

        // Address changes in the second access cycle
        do_clr();
        cyc(1'b1, 1'b0, 1'b1, 16'h0010, 32'h1234_5678, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 16'h0010, 32'h1234_5678, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 16'h0014, 32'h1234_5678, 1'b1, 1'b0);
        idle();
        idle();
        push("unstable_flags", O_FLAGS, 6'b001000);
        push("unstable_first", O_FIRST, 3);
        push("unstable_errcnt", O_ERRCNT, 1);
        push("unstable_pulses", O_PULSES, 1);
        drain();

        // Timeout: pready low for 20 access cycles
        do_clr();
        cyc(1'b1, 1'b0, 1'b0, 16'h0030, '0, 1'b0, 1'b0);
        repeat (TO - 1) cyc(1'b1, 1'b1, 1'b0, 16'h0030, '0, 1'b0, 1'b0);
        push("timeout_pre_flags", O_FLAGS, 0);
        drain();
        cyc(1'b1, 1'b1, 1'b0, 16'h0030, '0, 1'b0, 1'b0);
        push("timeout_at_flags", O_FLAGS, TO_EN ? 6'b100000 : 6'b000000);
        drain();
        repeat (20 - TO) cyc(1'b1, 1'b1, 1'b0, 16'h0030, '0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 16'h0030, '0, 1'b1, 1'b0);
        idle();
        push("timeout_flags", O_FLAGS, TO_EN ? 6'b100000 : 6'b000000);
        push("timeout_errcnt", O_ERRCNT, TO_EN ? 1 : 0);
        push("timeout_pulses", O_PULSES, TO_EN ? 1 : 0);
        push("timeout_xfer", O_XFER, 1);
        drain();

        // Back-to-back with penable high right after completion: codes 0 and 2 together
        do_clr();
        cyc(1'b1, 1'b0, 1'b0, 16'h0040, '0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 16'h0040, '0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 16'h0044, '0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 16'h0044, '0, 1'b1, 1'b0);
        idle();
        push("multi_flags", O_FLAGS, 6'b000101);
        push("multi_first", O_FIRST, 0);
        push("multi_errcnt", O_ERRCNT, 1);
        push("multi_pulses", O_PULSES, 1);
        push("multi_xfer", O_XFER, 2);
        drain();

        // psel dropped before pready
        do_clr();
        cyc(1'b1, 1'b0, 1'b0, 16'h0050, '0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 16'h0050, '0, 1'b0, 1'b0);
        idle();
        idle();
        push("abort_flags", O_FLAGS, 6'b010000);
        push("abort_first", O_FIRST, 4);
        push("abort_xfer", O_XFER, 0);
        drain();

        // clr at the same edge as a new violation
        clr = 1'b1;
        cyc(1'b1, 1'b1, 1'b0, 16'h0060, '0, 1'b0, 1'b0);
        clr = 1'b0;
        cyc(1'b1, 1'b1, 1'b0, 16'h0060, '0, 1'b1, 1'b0);
        idle();
        push("clrwin_flags", O_FLAGS, 6'b000001);
        push("clrwin_errcnt", O_ERRCNT, 1);
        push("clrwin_first", O_FIRST, 0);
        push("clrwin_xfer", O_XFER, 1);
        drain();

        // Checking disabled: violations ignored, transfers still counted
        do_clr();
        chk_en = 1'b0;
        cyc(1'b1, 1'b1, 1'b0, 16'h0070, '0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 16'h0070, '0, 1'b1, 1'b1);
        idle();
        chk_en = 1'b1;
        push("chkdis_flags", O_FLAGS, 0);
        push("chkdis_errcnt", O_ERRCNT, 0);
        push("chkdis_fvalid", O_FVALID, 0);
        push("chkdis_xfer", O_XFER, 1);
        push("chkdis_slv", O_SLV, 1);
        drain();

        // Counter saturation
        do_clr();
        for (int i = 0; i < 300; i++) xfer(16'(i * 4), $urandom, 1'($urandom_range(0, 1)), 0, 1'b1);
        push("sat_xfer", O_XFER, 255);
        push("sat_slv", O_SLV, 255);
        push("sat_errcnt", O_ERRCNT, 0);
        drain();
        do_clr();
        push("satclr_xfer", O_XFER, 0);
        push("satclr_slv", O_SLV, 0);
        drain();

        // Reset in the middle of an access phase
        do_clr();
        cyc(1'b1, 1'b1, 1'b1, 16'h0080, '0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 16'h0080, '0, 1'b0, 1'b0);
        #2 preset = 1'b1;
        psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0; pready = 0; pslverr = 0;
        #10 preset = 1'b0;
        @(posedge pclk);
        #1;
        push("midrst_flags", O_FLAGS, 0);
        push("midrst_errcnt", O_ERRCNT, 0);
        push("midrst_fvalid", O_FVALID, 0);
        drain();
        pulse_base = pulse_total;
        xfer(16'h0090, 32'hDEAD_BEEF, 1'b1, 1, 1'b0);
        idle();
        push("postrst_flags", O_FLAGS, 0);
        push("postrst_xfer", O_XFER, 1);
        push("postrst_pulses", O_PULSES, 0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cfs_apb_checker.md
CFS_APB_CHECKER -- requirements
Module: cfs_apb_checker

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 16, paddr width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, pwdata width.
REQ-003 The block SHALL have parameter CNT_WIDTH, default 8, width of every counter output.
REQ-004 The block SHALL have parameter TIMEOUT_CYCLES, default 16, maximum access-phase wait states before a timeout is flagged.
REQ-005 The block SHALL have one clock and an asynchronous, active-high reset, with ports named as follows.
- pclk  in  1  clock, all state on rising edge.
- preset  in  1  async active-high reset.
- chk_en  in  1  check enable; 0 suppresses flagging, FSM still tracks.
- clr  in  1  synchronous clear of err_flags, first_err, first_valid and counters.
- psel, penable, pwrite  in  1 each  observed APB control.
- paddr  in  ADDR_WIDTH  observed address.
- pwdata  in  DATA_WIDTH  observed write data.
- pready, pslverr  in  1 each  observed completer response.
- err_flags  out  6  sticky violation bits, index = error code.
- err_pulse  out  1  high one cycle for each edge at which any violation is detected.
- first_err  out  3  code of the first violation since reset/clr.
- first_valid  out  1  first_err holds a valid code.
- err_cnt  out  CNT_WIDTH  saturating count of violation edges.
- xfer_cnt  out  CNT_WIDTH  saturating count of completed transfers.
- slverr_cnt  out  CNT_WIDTH  saturating count of completed transfers with pslverr=1.

Function
REQ-006 FSM states: IDLE, SETUP, ACCESS, sampled at each pclk rising edge.
- IDLE->SETUP on psel=1.
- SETUP->ACCESS unconditionally.
- ACCESS->IDLE on pready=1 with psel=0 next, or on psel=0 (abort).
- ACCESS->SETUP on pready=1 with psel=1 (back-to-back); evaluated as completion, then new setup at the next edge.
REQ-007 SETUP entry captures paddr, pwrite and pwdata.
REQ-008 Error codes are as follows.
- 0: penable=1 in SETUP.
- 1: penable=0 or psel=0 in the cycle after SETUP.
- 2: penable=1 in the cycle after completion.
- 3: paddr/pwrite differ from the captured value in ACCESS, or pwdata differs when pwrite=1.
- 4: psel=0 in ACCESS before pready=1.
- 5: timeout.
REQ-009 Timeout: wait counter clears at SETUP and increments per ACCESS cycle with pready=0.
- Code 5 is flagged once per transfer when the counter equals TIMEOUT_CYCLES.
- The FSM stays in ACCESS after a timeout.
REQ-010 Detection to outputs: a violation sampled at edge N is visible on err_flags/err_pulse/err_cnt after edge N (zero added latency).
REQ-011 Multiple codes at one edge: all matching err_flags bits are set, err_cnt increments by 1, and first_err takes the lowest code.
REQ-012 A completed transfer is ACCESS with psel=penable=pready=1.
- xfer_cnt increments on each completed transfer.
- slverr_cnt also increments if pslverr=1.
REQ-013 All counters saturate at all-ones and never wrap.
REQ-014 clr together with a new violation at the same edge: the violation wins; the flag is set and the counter reads 1.
REQ-015 chk_en=0 blocks all err_* and first_* updates; xfer_cnt and slverr_cnt keep counting.

Reset
REQ-016 preset=1 SHALL asynchronously set FSM=IDLE and all outputs, counters, captured values and the wait counter to 0.
REQ-017 Reset mid-transfer SHALL discard the transfer; after release the FSM resumes in IDLE with no violation for the partial transfer.

Configuration
REQ-018 Macro CFS_APB_CHECKER_TIMEOUT_EN defined: code 5 and the wait counter SHALL be implemented per REQ-009.
REQ-019 Macro CFS_APB_CHECKER_TIMEOUT_EN undefined: the wait counter SHALL be absent and err_flags[5] tied to 0.

Structure
REQ-020 Package cfs_apb_checker_pkg SHALL hold the FSM state enum, error-code constants (ERR_PEN_SETUP=0 ... ERR_TIMEOUT=5) and NUM_ERR=6.
REQ-021 Counters SHALL use one sub-module cfs_apb_sat_cnt (parameter WIDTH; inputs inc, clr; output count) instantiated three times.

Verification
REQ-022 Legal write: paddr=0x0010, pwdata=0xA5A5A5A5, 2 wait states -> xfer_cnt=1, err_flags=0, err_pulse never high.
REQ-023 penable=1 in the setup cycle -> err_flags=6'b000001, first_err=0, err_cnt=1.
REQ-024 paddr changes 0x0010->0x0014 in the second access cycle -> err_flags[3]=1, single err_pulse.
REQ-025 pready held 0 for 20 cycles with TIMEOUT_CYCLES=16 -> err_flags[5]=1 after the 16th wait edge, err_cnt=1.
- Same stimulus with the macro undefined -> err_flags=0.
REQ-026 300 legal transfers with pslverr=1, CNT_WIDTH=8 -> xfer_cnt=slverr_cnt=255.
- clr then asserted -> counters read 0.
REQ-027 preset asserted mid-access, then a legal transfer -> err_flags=0, xfer_cnt=1.
